// File: rtl/aes_inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms one column per
// clock through a single shared GF(2^8) column datapath, returns the registered result.
module aes_inv_mix_columns_iter (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    logic [1:0]   col_cnt;
    logic [127:0] work_q;
    logic [6:0]   col_base;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a2 ^ a;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a4 ^ a;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] a);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return a8 ^ a4 ^ a2;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {b3, b2, b1, b0};
    endfunction

    // The one column datapath instance, steered by col_cnt.
    assign col_base = {col_cnt, 5'd0};
    assign col_in   = work_q[col_base +: 32];
    assign col_out  = inv_mix_col(col_in);

    // Handshake/status outputs depend only on the registered FSM state.
    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q == CALC) || (fsm_q == DONE);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            col_cnt <= 2'd0;
            // NOTE: the working register is reset too; it costs little and keeps
            // a discarded mid-flight state from lingering after reset.
            work_q  <= '0;
            state_o <= '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        work_q  <= state_i;
                        col_cnt <= 2'd0;
                        fsm_q   <= CALC;
                    end
                end
                CALC: begin
                    state_o[col_base +: 32] <= col_out;
                    col_cnt                 <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        fsm_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_q <= IDLE;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_mix_columns_iter.sv
// Directed self-checking bench for aes_inv_mix_columns_iter: known vectors, fixed
// points, back-pressure, mid-CALC reset and back-to-back with a software model.
module tb_aes_inv_mix_columns_iter;

    logic         clk_i;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] state_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] state_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    aes_inv_mix_columns_iter dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .state_i     (state_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .state_o     (state_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference multiply: plain shift-and-add over GF(2^8).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inverse);
        logic [7:0]   m [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inverse) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    // Launch one state, check timing of out_valid_o, then return the result.
    task automatic run_txn(input string tag, input logic [127:0] s_in,
                           input logic [127:0] expected);
        int n;
        state_i    = s_in;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        state_i    = '0;
        check({tag, "_busy_after_accept"}, busy_o, 1'b1);
        n = 0;
        while (!out_valid_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_result"}, state_o, expected);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, "_back_idle"}, in_ready_o, 1'b1);
    endtask

    localparam logic [127:0] FULL_IN  = 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e;
    localparam logic [127:0] FULL_OUT = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;

    logic [127:0] held;
    logic [127:0] vecs [3];
    logic [127:0] exps [3];
    logic [127:0] got  [3];
    int           acc_cyc [3];
    int           n_acc, n_out, budget;

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        state_i     = '0;
        #12;
        check("reset_in_ready",  in_ready_o,  1'b1);
        check("reset_out_valid", out_valid_o, 1'b0);
        check("reset_busy",      busy_o,      1'b0);
        check("reset_state_o",   state_o,     '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;

        run_txn("col0", {96'h0, 32'hbca14d8e}, {96'h0, 32'h455313db});
        run_txn("full", FULL_IN, FULL_OUT);
        run_txn("fix_c6", {16{8'hc6}}, {16{8'hc6}});
        run_txn("fix_01", {16{8'h01}}, {16{8'h01}});
        run_txn("fix_00", '0, '0);

        // Back-pressure: DONE must hold and ignore a new input pulse.
        state_i    = FULL_IN;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (4) tick();
        check("bp_valid_start", out_valid_o, 1'b1);
        held = state_o;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                state_i    = {16{8'h5a}};
                in_valid_i = 1'b1;
            end else begin
                in_valid_i = 1'b0;
            end
            tick();
            check("bp_valid", out_valid_o, 1'b1);
            check("bp_state", state_o, held);
            check("bp_in_ready", in_ready_o, 1'b0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("bp_release_idle", in_ready_o, 1'b1);
        check("bp_release_valid", out_valid_o, 1'b0);
        check("bp_release_state", state_o, FULL_OUT);

        // Reset in the middle of CALC.
        state_i    = {16{8'h77}};
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b0;
        #1;
        check("rst_mid_in_ready",  in_ready_o,  1'b1);
        check("rst_mid_out_valid", out_valid_o, 1'b0);
        check("rst_mid_busy",      busy_o,      1'b0);
        check("rst_mid_state_o",   state_o,     '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        run_txn("post_rst", FULL_IN, FULL_OUT);

        // Back-to-back with in_valid_i and out_ready_i held high.
        vecs[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        vecs[1] = mix_model(vecs[0], 1'b0);
        vecs[2] = mix_model(128'h3243f6a8_885a308d_313198a2_e0370734, 1'b0);
        for (int i = 0; i < 3; i++) exps[i] = mix_model(vecs[i], 1'b1);
        n_acc = 0;
        n_out = 0;
        budget = 0;
        state_i     = vecs[0];
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        while (n_out < 3 && budget < 100) begin
            @(posedge clk_i);
            if (in_ready_o && in_valid_i && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (out_valid_o && out_ready_i) begin
                got[n_out] = state_o;
                n_out++;
            end
            #1;
            if (n_acc < 3) state_i = vecs[n_acc];
            else in_valid_i = 1'b0;
            budget++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("b2b_count", n_out, 3);
        for (int i = 0; i < 3; i++) check($sformatf("b2b_result%0d", i), got[i], exps[i]);
        check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 6);
        check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 6);
        check("b2b_roundtrip", got[1], vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
